memory_board_ctrl: RTL and testbench

MEMORY_BOARD_CTRL -- requirements
Module: memory_board_ctrl

---
 rtl/memory_board_pkg.sv | 21 ++
 rtl/memory_cell_array.sv | 52 +++++
 rtl/memory_board_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_memory_board_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_board_pkg.sv
// Shared types for the memory (concentration) board controller.
package memory_board_pkg;

    // Per-cell visibility state as seen on the cell_state output.
    typedef enum logic [1:0] {
        HIDDEN  = 2'd0,
        UP      = 2'd1,
        MATCHED = 2'd2
    } cell_state_e;

    // Turn sequencing: first pick, second pick, mismatch reveal, game over.
    typedef enum logic [1:0] {
        PICK1 = 2'd0,
        PICK2 = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } fsm_state_e;

    localparam int CELL_W = 2;

endpackage

// File: rtl/memory_cell_array.sv
// Per-cell state storage for the board plus the "every cell matched" reduction.
// The reduction looks at the next-state value so the controller can go straight
// to DONE on the edge that matches the final pair.
module memory_cell_array
    import memory_board_pkg::*;
#(
    parameter int NUM_CELLS = 16,
    localparam int IDX_W    = $clog2(NUM_CELLS)
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_up_en,
    input  logic [IDX_W-1:0]           i_up_idx,
    input  logic                       i_match_en,
    input  logic [IDX_W-1:0]           i_match_a,
    input  logic [IDX_W-1:0]           i_match_b,
    input  logic                       i_hide_en,
    output logic [CELL_W*NUM_CELLS-1:0] o_cell_state,
    output logic                       o_all_matched_next
);

    logic [NUM_CELLS-1:0] w_next_matched;

    for (genvar g = 0; g < NUM_CELLS; g++) begin : g_cell
        localparam logic [IDX_W-1:0] IDX = IDX_W'(g);
        cell_state_e r_state;
        cell_state_e w_next;

        // Next state: hide-all-UP first, then a flip or a match overrides it
        always_comb begin
            w_next = r_state;
            if (i_hide_en && r_state == UP)
                w_next = HIDDEN;
            if (i_up_en && i_up_idx == IDX)
                w_next = UP;
            if (i_match_en && (i_match_a == IDX || i_match_b == IDX))
                w_next = MATCHED;
        end

        // Cell state register
        always_ff @(posedge i_clk) begin
            if (i_rst) r_state <= HIDDEN;
            else       r_state <= w_next;
        end

        assign o_cell_state[CELL_W*g +: CELL_W] = r_state;
        assign w_next_matched[g] = (w_next == MATCHED);
    end

    assign o_all_matched_next = &w_next_matched;

endmodule

// File: rtl/memory_board_ctrl.sv
// Memory-game board controller: cursor, turn FSM, pair matching, scoring.
// Optional feature: define MEMORY_BOARD_TURN_TIMEOUT_EN to compile in a turn
// timeout (parameter TURN_TIMEOUT, output o_timeout_pulse).
module memory_board_ctrl
    import memory_board_pkg::*;
#(
    parameter int NUM_CELLS   = 16,
    parameter int LABEL_W     = 4,
    parameter int NUM_PLAYERS = 2,
    parameter int REVEAL_CYC  = 8,
    parameter int SCORE_W     = 4
`ifdef MEMORY_BOARD_TURN_TIMEOUT_EN
   ,parameter int TURN_TIMEOUT = 1024
`endif
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [NUM_CELLS*LABEL_W-1:0]     i_labels,
    input  logic                             i_move,
    input  logic                             i_move_dir,
    input  logic                             i_select,
    output logic [$clog2(NUM_CELLS)-1:0]     o_cursor,
    output logic [2*NUM_CELLS-1:0]           o_cell_state,
    output logic [$clog2(NUM_PLAYERS)-1:0]   o_player,
    output logic [NUM_PLAYERS*SCORE_W-1:0]   o_scores,
    output logic                             o_match_pulse,
    output logic                             o_done
`ifdef MEMORY_BOARD_TURN_TIMEOUT_EN
   ,output logic                             o_timeout_pulse
`endif
);

    localparam int IDX_W  = $clog2(NUM_CELLS);
    localparam int PLY_W  = $clog2(NUM_PLAYERS);
    localparam int HOLD_W = $clog2(REVEAL_CYC + 1);

    fsm_state_e                           r_state;
    logic [IDX_W-1:0]                     r_cursor;
    logic [IDX_W-1:0]                     r_first;
    logic [PLY_W-1:0]                     r_player;
    logic [NUM_PLAYERS-1:0][SCORE_W-1:0]  r_scores;
    logic [HOLD_W-1:0]                    r_hold_cnt;
    logic                                 r_match_pulse;
    logic                                 r_done;

    logic [2*NUM_CELLS-1:0] w_cells;
    logic                   w_all_next;
    logic                   w_in_pick;
    logic                   w_cur_hidden;
    logic                   w_accept;
    logic [LABEL_W-1:0]     w_lbl_first;
    logic [LABEL_W-1:0]     w_lbl_cur;
    logic                   w_labels_eq;
    logic                   w_up_en;
    logic                   w_match_en;
    logic                   w_hold_exit;
    logic                   w_hide_en;
    logic                   w_timeout;
    logic [PLY_W-1:0]       w_next_player;

    // Select always acts on the pre-move cursor, so everything keys off r_cursor
    assign w_in_pick    = (r_state == PICK1) || (r_state == PICK2);
    assign w_cur_hidden = (w_cells[2*r_cursor +: 2] == HIDDEN);
    assign w_accept     = i_select && w_cur_hidden && w_in_pick;
    assign w_lbl_first  = i_labels[r_first*LABEL_W +: LABEL_W];
    assign w_lbl_cur    = i_labels[r_cursor*LABEL_W +: LABEL_W];
    assign w_labels_eq  = (w_lbl_first == w_lbl_cur);
    assign w_up_en      = w_accept && ((r_state == PICK1) || !w_labels_eq);
    assign w_match_en   = w_accept && (r_state == PICK2) && w_labels_eq;
    assign w_hold_exit  = (r_state == HOLD) && (r_hold_cnt == HOLD_W'(REVEAL_CYC - 1));
    assign w_hide_en    = w_hold_exit || w_timeout;
    assign w_next_player = (r_player == PLY_W'(NUM_PLAYERS - 1)) ? '0 : r_player + 1'b1;

    memory_cell_array #(.NUM_CELLS(NUM_CELLS)) u_cells (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_up_en            (w_up_en),
        .i_up_idx           (r_cursor),
        .i_match_en         (w_match_en),
        .i_match_a          (r_first),
        .i_match_b          (r_cursor),
        .i_hide_en          (w_hide_en),
        .o_cell_state       (w_cells),
        .o_all_matched_next (w_all_next)
    );

`ifdef MEMORY_BOARD_TURN_TIMEOUT_EN
    localparam int TO_W = $clog2(TURN_TIMEOUT + 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout_pulse;

    assign w_timeout = w_in_pick && !w_accept && (r_to_cnt == TO_W'(TURN_TIMEOUT - 1));

    // Idle-turn counter: runs only while waiting for a pick
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_to_cnt        <= '0;
            r_timeout_pulse <= 1'b0;
        end else begin
            r_timeout_pulse <= w_timeout;
            if (!w_in_pick || w_accept || w_timeout) r_to_cnt <= '0;
            else                                     r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign o_timeout_pulse = r_timeout_pulse;
`else
    assign w_timeout = 1'b0;
`endif

    // Cursor: wraps both ways, frozen once the game is over
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_cursor <= '0;
        else if (i_move && r_state != DONE) begin
            if (i_move_dir)
                r_cursor <= (r_cursor == '0) ? IDX_W'(NUM_CELLS - 1) : r_cursor - 1'b1;
            else
                r_cursor <= (r_cursor == IDX_W'(NUM_CELLS - 1)) ? '0 : r_cursor + 1'b1;
        end
    end

    // Turn FSM with scoring, reveal timer and registered status outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= PICK1;
            r_first       <= '0;
            r_player      <= '0;
            r_scores      <= '0;
            r_hold_cnt    <= '0;
            r_match_pulse <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_match_pulse <= 1'b0;
            case (r_state)
                PICK1: begin
                    if (w_accept) begin
                        r_first <= r_cursor;
                        r_state <= PICK2;
                    end else if (w_timeout) begin
                        r_player <= w_next_player;
                    end
                end
                PICK2: begin
                    if (w_match_en) begin
                        if (r_scores[r_player] != '1)
                            r_scores[r_player] <= r_scores[r_player] + 1'b1;
                        r_match_pulse <= 1'b1;
                        r_done        <= w_all_next;
                        r_state       <= w_all_next ? DONE : PICK1;
                    end else if (w_accept) begin
                        r_hold_cnt <= '0;
                        r_state    <= HOLD;
                    end else if (w_timeout) begin
                        r_player <= w_next_player;
                        r_state  <= PICK1;
                    end
                end
                HOLD: begin
                    if (w_hold_exit) begin
                        r_hold_cnt <= '0;
                        r_player   <= w_next_player;
                        r_state    <= PICK1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_cursor      = r_cursor;
    assign o_cell_state  = w_cells;
    assign o_player      = r_player;
    assign o_scores      = r_scores;
    assign o_match_pulse = r_match_pulse;
    assign o_done        = r_done;

endmodule

// File: tb/tb_memory_board_ctrl.sv
// Self-checking bench for memory_board_ctrl: stimulus table, directed game
// sequences, and randomized play against a behavioural game model.
module tb_memory_board_ctrl;
    import memory_board_pkg::*;

    localparam int N  = 16;
    localparam int LW = 4;
    localparam int NP = 2;
    localparam int RC = 8;
    localparam int SW = 4;
`ifdef MEMORY_BOARD_TURN_TIMEOUT_EN
    localparam int TT = 20;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N*LW-1:0]   labels = '0;
    logic              move = 1'b0, move_dir = 1'b0, select = 1'b0;
    logic [3:0]        cursor;
    logic [2*N-1:0]    cell_state;
    logic [0:0]        player;
    logic [NP*SW-1:0]  scores;
    logic              match_pulse, done;
`ifdef MEMORY_BOARD_TURN_TIMEOUT_EN
    logic              timeout_pulse;
`endif

    always #5 clk = ~clk;

    memory_board_ctrl #(
        .NUM_CELLS(N), .LABEL_W(LW), .NUM_PLAYERS(NP), .REVEAL_CYC(RC), .SCORE_W(SW)
`ifdef MEMORY_BOARD_TURN_TIMEOUT_EN
       ,.TURN_TIMEOUT(TT)
`endif
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_labels(labels), .i_move(move),
        .i_move_dir(move_dir), .i_select(select), .o_cursor(cursor),
        .o_cell_state(cell_state), .o_player(player), .o_scores(scores),
        .o_match_pulse(match_pulse), .o_done(done)
`ifdef MEMORY_BOARD_TURN_TIMEOUT_EN
       ,.o_timeout_pulse(timeout_pulse)
`endif
    );

    // ---------------- behavioural game model ----------------
    int m_lbl[N];
    int m_cell[N];          // 0 hidden, 1 face up, 2 matched
    int m_score[NP];
    int m_cursor, m_player, m_first, m_hold, m_idle;
    bit m_pulse, m_done, m_tpulse;

    int n_chk = 0;
    int n_fail = 0;

    function automatic logic [2*N-1:0] m_cells_vec();
        logic [2*N-1:0] v;
        for (int i = 0; i < N; i++) v[2*i +: 2] = 2'(m_cell[i]);
        return v;
    endfunction

    function automatic logic [NP*SW-1:0] m_scores_vec();
        logic [NP*SW-1:0] v;
        for (int i = 0; i < NP; i++) v[i*SW +: SW] = SW'(m_score[i]);
        return v;
    endfunction

    function automatic void m_hide_up();
        for (int i = 0; i < N; i++) if (m_cell[i] == 1) m_cell[i] = 0;
    endfunction

    function automatic void model_step(bit r, bit mv, bit d, bit s);
        bit all;
        if (r) begin
            for (int i = 0; i < N; i++) m_cell[i] = 0;
            for (int i = 0; i < NP; i++) m_score[i] = 0;
            m_cursor = 0; m_player = 0; m_first = -1; m_hold = 0; m_idle = 0;
            m_pulse = 0; m_done = 0; m_tpulse = 0;
            return;
        end
        m_pulse = 0; m_tpulse = 0;
        if (m_done) return;
        if (m_hold > 0) begin
            m_idle = 0;
            m_hold--;
            if (m_hold == 0) begin m_hide_up(); m_player = (m_player + 1) % NP; end
        end else if (s && m_cell[m_cursor] == 0) begin
            m_idle = 0;
            if (m_first < 0) begin
                m_cell[m_cursor] = 1; m_first = m_cursor;
            end else if (m_lbl[m_first] == m_lbl[m_cursor]) begin
                m_cell[m_cursor] = 2; m_cell[m_first] = 2; m_first = -1;
                if (m_score[m_player] < (1 << SW) - 1) m_score[m_player]++;
                m_pulse = 1;
                all = 1;
                for (int i = 0; i < N; i++) if (m_cell[i] != 2) all = 0;
                m_done = all;
            end else begin
                m_cell[m_cursor] = 1; m_first = -1; m_hold = RC;
            end
        end else begin
`ifdef MEMORY_BOARD_TURN_TIMEOUT_EN
            m_idle++;
            if (m_idle == TT) begin
                m_hide_up(); m_first = -1; m_player = (m_player + 1) % NP;
                m_tpulse = 1; m_idle = 0;
            end
`endif
        end
        if (mv) m_cursor = d ? (m_cursor + N - 1) % N : (m_cursor + 1) % N;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("cursor", 64'(cursor), 64'(m_cursor));
        chk("cell_state", 64'(cell_state), 64'(m_cells_vec()));
        chk("player", 64'(player), 64'(m_player));
        chk("scores", 64'(scores), 64'(m_scores_vec()));
        chk("match_pulse", 64'(match_pulse), 64'(m_pulse));
        chk("done", 64'(done), 64'(m_done));
`ifdef MEMORY_BOARD_TURN_TIMEOUT_EN
        chk("timeout_pulse", 64'(timeout_pulse), 64'(m_tpulse));
`endif
    endtask

    task automatic cyc(bit mv, bit d, bit s);
        move = mv; move_dir = d; select = s;
        @(posedge clk);
        model_step(0, mv, d, s);
        #1;
        move = 0; select = 0;
        compare_all();
    endtask

    // Reset with move/select asserted to exercise reset priority
    task automatic do_reset();
        for (int i = 0; i < N; i++) labels[i*LW +: LW] = LW'(m_lbl[i]);
        rst = 1; move = 1; move_dir = 1; select = 1;
        @(posedge clk);
        model_step(1, 0, 0, 0);
        #1;
        rst = 0; move = 0; select = 0;
        compare_all();
    endtask

    task automatic goto_cell(int idx);
        for (int k = 0; k < N && m_cursor != idx; k++) cyc(1, 0, 0);
    endtask

    typedef struct {
        bit mv;
        bit dir;
        bit sel;
        int exp_cursor;
    } vec_t;
    vec_t tbl[18];

    int pa[8] = '{0, 1, 3, 5, 7, 9, 11, 14};
    int pb[8] = '{13, 2, 4, 6, 8, 10, 12, 15};

    initial begin
        // fixed board: pairs (0,13) (1,2) (3,4) ... (11,12) (14,15)
        for (int p = 0; p < 8; p++) begin
            m_lbl[pa[p]] = (p == 0) ? 1 : p + 2;
            m_lbl[pb[p]] = (p == 0) ? 1 : p + 2;
        end

        // cursor wrap table: one decrement from 0, one increment back, 16 increments
        tbl[0] = '{1, 1, 0, 15};
        tbl[1] = '{1, 0, 0, 0};
        for (int i = 0; i < 16; i++) tbl[2 + i] = '{1, 0, 0, (i + 1) % 16};

        repeat (2) @(posedge clk);
        do_reset();
        chk("rst_cursor", 64'(cursor), 64'd0);
        chk("rst_cells", 64'(cell_state), 64'd0);
        chk("rst_scores", 64'(scores), 64'd0);
        chk("rst_done", 64'(done), 64'd0);

        foreach (tbl[i]) begin
            cyc(tbl[i].mv, tbl[i].dir, tbl[i].sel);
            chk("tbl_cursor", 64'(cursor), 64'(tbl[i].exp_cursor));
        end

        // match of cells 0 and 13
        do_reset();
        cyc(0, 0, 1);
        chk("m_up0", 64'(cell_state), 64'h1);
        repeat (13) cyc(1, 0, 0);
        cyc(0, 0, 1);
        chk("m_cells", 64'(cell_state), 64'h0800_0002);
        chk("m_score", 64'(scores), 64'h01);
        chk("m_pulse", 64'(match_pulse), 64'd1);
        chk("m_player", 64'(player), 64'd0);
        cyc(0, 0, 0);
        chk("m_pulse_off", 64'(match_pulse), 64'd0);

        // mismatch of cells 0 and 1, with selects on a hidden cell during reveal
        do_reset();
        cyc(0, 0, 1);
        cyc(1, 0, 0);
        cyc(0, 0, 1);
        chk("mm_up", 64'(cell_state), 64'h5);
        cyc(1, 0, 0);
        chk("mm_up", 64'(cell_state), 64'h5);
        for (int k = 0; k < 6; k++) begin
            cyc(0, 0, 1);
            chk("mm_hold", 64'(cell_state), 64'h5);
        end
        cyc(0, 0, 1);
        chk("mm_hidden", 64'(cell_state), 64'h0);
        chk("mm_player", 64'(player), 64'd1);

        // illegal picks: same cell twice, then a matched cell
        do_reset();
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        chk("il_same", 64'(cell_state), 64'h1);
        goto_cell(13);
        cyc(0, 0, 1);
        chk("il_match", 64'(cell_state), 64'h0800_0002);
        goto_cell(0);
        cyc(0, 0, 1);
        chk("il_matched_sel", 64'(cell_state), 64'h0800_0002);
        chk("il_player", 64'(player), 64'd0);
        chk("il_score", 64'(scores), 64'h01);

        // completion: player 0 clears the board
        do_reset();
        for (int p = 0; p < 8; p++) begin
            goto_cell(pa[p]); cyc(0, 0, 1);
            goto_cell(pb[p]); cyc(0, 0, 1);
        end
        chk("c_done", 64'(done), 64'd1);
        chk("c_score", 64'(scores), 64'h08);
        chk("c_cells", 64'(cell_state), 64'hAAAA_AAAA);
        cyc(1, 0, 1);
        cyc(1, 1, 1);
        chk("c_cursor_frozen", 64'(cursor), 64'd15);
        chk("c_done_hold", 64'(done), 64'd1);
        do_reset();
        chk("c_rst_done", 64'(done), 64'd0);
        chk("c_rst_cells", 64'(cell_state), 64'd0);

`ifdef MEMORY_BOARD_TURN_TIMEOUT_EN
        do_reset();
        cyc(0, 0, 1);
        repeat (TT - 1) cyc(0, 0, 0);
        chk("to_still_up", 64'(cell_state), 64'h1);
        chk("to_no_pulse", 64'(timeout_pulse), 64'd0);
        cyc(0, 0, 0);
        chk("to_hidden", 64'(cell_state), 64'h0);
        chk("to_player", 64'(player), 64'd1);
        chk("to_pulse", 64'(timeout_pulse), 64'd1);
        cyc(0, 0, 0);
        chk("to_pulse_off", 64'(timeout_pulse), 64'd0);
`endif

        // randomized games on shuffled boards
        for (int g = 0; g < 6; g++) begin
            int perm[N];
            for (int i = 0; i < N; i++) perm[i] = i / 2 + 1;
            for (int i = N - 1; i > 0; i--) begin
                int j, t;
                j = int'($urandom_range(i, 0));
                t = perm[i]; perm[i] = perm[j]; perm[j] = t;
            end
            for (int i = 0; i < N; i++) m_lbl[i] = perm[i];
            do_reset();
            for (int c = 0; c < 500; c++)
                cyc(($urandom_range(2, 0) == 0), 1'($urandom), ($urandom_range(1, 0) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
